// File: rtl/control_unit_pkg.sv
// Shared definitions for the 8-bit CPU control path: opcodes, bus/ALU select codes,
// FSM state encoding and opcode classification helpers.
package control_unit_pkg;

  typedef enum logic [4:0] {
    S_FETCH_0  = 5'd0,
    S_FETCH_1  = 5'd1,
    S_FETCH_2  = 5'd2,
    S_DECODE_3 = 5'd3,
    S_EXEC_4   = 5'd4,
    S_EXEC_5   = 5'd5,
    S_EXEC_6   = 5'd6,
    S_EXEC_7   = 5'd7,
    S_EXEC_8   = 5'd8
  } state_t;

  typedef enum logic [2:0] {
    CL_ILLEGAL, CL_LD_IMM, CL_LD_DIR, CL_ST_DIR, CL_ALU_AB, CL_ALU_UN, CL_BRANCH
  } op_class_t;

  localparam logic [7:0] OPC_LDA_IMM = 8'h86, OPC_LDA_DIR = 8'h87;
  localparam logic [7:0] OPC_LDB_IMM = 8'h88, OPC_LDB_DIR = 8'h89;
  localparam logic [7:0] OPC_STA_DIR = 8'h96, OPC_STB_DIR = 8'h97;
  localparam logic [7:0] OPC_ADD_AB  = 8'h42, OPC_SUB_AB  = 8'h43;
  localparam logic [7:0] OPC_AND_AB  = 8'h44, OPC_OR_AB   = 8'h45;
  localparam logic [7:0] OPC_INCA    = 8'h46, OPC_INCB    = 8'h47;
  localparam logic [7:0] OPC_DECA    = 8'h48, OPC_DECB    = 8'h49;
  localparam logic [7:0] OPC_BRA = 8'h20, OPC_BMI = 8'h21, OPC_BPL = 8'h22;
  localparam logic [7:0] OPC_BEQ = 8'h23, OPC_BNE = 8'h24, OPC_BVS = 8'h25;
  localparam logic [7:0] OPC_BVC = 8'h26, OPC_BCS = 8'h27, OPC_BCC = 8'h28;

  localparam logic [2:0] ALU_ADD = 3'b000, ALU_INC = 3'b001, ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_DEC = 3'b011, ALU_AND = 3'b100, ALU_OR  = 3'b101;

  localparam logic [1:0] BUS1_PC  = 2'b00, BUS1_A    = 2'b01, BUS1_B   = 2'b10;
  localparam logic [1:0] BUS2_ALU = 2'b00, BUS2_BUS1 = 2'b01, BUS2_MEM = 2'b10;

  function automatic op_class_t op_class(input logic [7:0] ir);
    case (ir)
      OPC_LDA_IMM, OPC_LDB_IMM:                       return CL_LD_IMM;
      OPC_LDA_DIR, OPC_LDB_DIR:                       return CL_LD_DIR;
      OPC_STA_DIR, OPC_STB_DIR:                       return CL_ST_DIR;
      OPC_ADD_AB, OPC_SUB_AB, OPC_AND_AB, OPC_OR_AB:  return CL_ALU_AB;
      OPC_INCA, OPC_INCB, OPC_DECA, OPC_DECB:         return CL_ALU_UN;
      OPC_BRA, OPC_BMI, OPC_BPL, OPC_BEQ, OPC_BNE,
      OPC_BVS, OPC_BVC, OPC_BCS, OPC_BCC:             return CL_BRANCH;
      default:                                        return CL_ILLEGAL;
    endcase
  endfunction

  function automatic logic [2:0] alu_sel_of(input logic [7:0] ir);
    case (ir)
      OPC_SUB_AB:           return ALU_SUB;
      OPC_AND_AB:           return ALU_AND;
      OPC_OR_AB:            return ALU_OR;
      OPC_INCA, OPC_INCB:   return ALU_INC;
      OPC_DECA, OPC_DECB:   return ALU_DEC;
      default:              return ALU_ADD;
    endcase
  endfunction

  // Instructions whose register operand/destination is B rather than A.
  function automatic logic uses_b(input logic [7:0] ir);
    case (ir)
      OPC_LDB_IMM, OPC_LDB_DIR, OPC_STB_DIR, OPC_INCB, OPC_DECB: return 1'b1;
      default:                                                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_branch_eval.sv
// Combinational branch condition: decides whether the branch opcode in IR is taken
// given the current NZVC flags.
module control_unit_branch_eval
  import control_unit_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CCR_W  = 4
) (
  input  logic [DATA_W-1:0] ir,
  input  logic [CCR_W-1:0]  ccr,
  output logic              taken
);

  always_comb begin
    taken = 1'b0;
    case (ir)
      OPC_BRA: taken = 1'b1;
      OPC_BMI: taken = ccr[3];
      OPC_BPL: taken = ~ccr[3];
      OPC_BEQ: taken = ccr[2];
      OPC_BNE: taken = ~ccr[2];
      OPC_BVS: taken = ccr[1];
      OPC_BVC: taken = ~ccr[1];
      OPC_BCS: taken = ccr[0];
      OPC_BCC: taken = ~ccr[0];
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore sequencer for the 8-bit CPU data path: fetch, decode and per-class execute
// steps; outputs decode from the state register, IR_out and CCR_Result.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CCR_W  = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] IR_out,
  input  logic [CCR_W-1:0]  CCR_Result,
  output logic              IR_Load,
  output logic              MAR_Load,
  output logic              PC_Load,
  output logic              PC_Inc,
  output logic              A_Load,
  output logic              B_Load,
  output logic              CCR_Load,
  output logic [2:0]        ALU_Sel,
  output logic [1:0]        Bus1_Sel,
  output logic [1:0]        Bus2_Sel,
  output logic              write
);

  state_t    state_q, state_d;
  op_class_t cls;
  logic      taken;
  logic      b_side;

  assign cls    = op_class(IR_out);
  assign b_side = uses_b(IR_out);

  control_unit_branch_eval #(.DATA_W(DATA_W), .CCR_W(CCR_W)) u_branch_eval (
    .ir    (IR_out),
    .ccr   (CCR_Result),
    .taken (taken)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) state_q <= S_FETCH_0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = S_FETCH_0;
    IR_Load  = 1'b0;
    MAR_Load = 1'b0;
    PC_Load  = 1'b0;
    PC_Inc   = 1'b0;
    A_Load   = 1'b0;
    B_Load   = 1'b0;
    CCR_Load = 1'b0;
    ALU_Sel  = ALU_ADD;
    Bus1_Sel = BUS1_PC;
    Bus2_Sel = BUS2_ALU;
    write    = 1'b0;

    case (state_q)
      S_FETCH_0:  state_d = S_FETCH_1;
      S_FETCH_1:  state_d = S_FETCH_2;
      S_FETCH_2:  state_d = S_DECODE_3;
      S_DECODE_3: state_d = (cls == CL_ILLEGAL) ? S_FETCH_0 : S_EXEC_4;
      S_EXEC_4: begin
        if (cls inside {CL_LD_IMM, CL_LD_DIR, CL_ST_DIR} || (cls == CL_BRANCH && taken))
          state_d = S_EXEC_5;
      end
      S_EXEC_5:   state_d = S_EXEC_6;
      S_EXEC_6:   if (cls inside {CL_LD_DIR, CL_ST_DIR}) state_d = S_EXEC_7;
      S_EXEC_7:   if (cls == CL_LD_DIR) state_d = S_EXEC_8;
      default:    state_d = S_FETCH_0;
    endcase

    // Strobes are masked while Reset is low so an aborted instruction commits nothing.
    if (Reset) begin
      case (state_q)
        S_FETCH_0: begin
          Bus2_Sel = BUS2_BUS1;
          MAR_Load = 1'b1;
        end
        S_FETCH_1: PC_Inc = 1'b1;
        S_FETCH_2: begin
          Bus2_Sel = BUS2_MEM;
          IR_Load  = 1'b1;
        end
        S_EXEC_4: begin
          case (cls)
            CL_LD_IMM, CL_LD_DIR, CL_ST_DIR: begin
              Bus2_Sel = BUS2_BUS1;
              MAR_Load = 1'b1;
            end
            CL_BRANCH: begin
              if (taken) begin
                Bus2_Sel = BUS2_BUS1;
                MAR_Load = 1'b1;
              end else begin
                PC_Inc = 1'b1;
              end
            end
            CL_ALU_AB, CL_ALU_UN: begin
              Bus1_Sel = b_side ? BUS1_B : BUS1_A;
              ALU_Sel  = alu_sel_of(IR_out);
              Bus2_Sel = BUS2_ALU;
              A_Load   = ~b_side;
              B_Load   = b_side;
              CCR_Load = 1'b1;
            end
            default: ;
          endcase
        end
        S_EXEC_5: PC_Inc = cls inside {CL_LD_IMM, CL_LD_DIR, CL_ST_DIR};
        S_EXEC_6: begin
          case (cls)
            CL_LD_IMM: begin
              Bus2_Sel = BUS2_MEM;
              A_Load   = ~b_side;
              B_Load   = b_side;
            end
            CL_LD_DIR, CL_ST_DIR: begin
              Bus2_Sel = BUS2_MEM;
              MAR_Load = 1'b1;
            end
            CL_BRANCH: begin
              Bus2_Sel = BUS2_MEM;
              PC_Load  = 1'b1;
            end
            default: ;
          endcase
        end
        S_EXEC_7: begin
          if (cls == CL_ST_DIR) begin
            Bus1_Sel = b_side ? BUS1_B : BUS1_A;
            write    = 1'b1;
          end
        end
        S_EXEC_8: begin
          if (cls == CL_LD_DIR) begin
            Bus2_Sel = BUS2_MEM;
            A_Load   = ~b_side;
            B_Load   = b_side;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
